// File: rtl/dart_rx_word.sv
// 8N1 serial receiver that pairs two bytes into one 16-bit word (first byte high).
// 16x oversampling with mid-bit sampling, sticky framing-error flag, inter-byte timeout.
module dart_rx_word #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD_RATE    = 9600,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        rxd,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        rx_error
);

  // state     | meaning
  // S_IDLE    | line idle, watching for a falling edge
  // S_START   | start bit seen, confirm low at its mid-point
  // S_DATA    | sampling 8 data bits, LSB first
  // S_STOP    | sampling the stop bit
  // S_WAIT_HI | framing error, wait for line to return high
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_WAIT_HI = 3'd4;

  localparam int DIV      = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TO_TICKS = TIMEOUT_BITS * 16;
  localparam int TO_W     = $clog2(TO_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TO_TICKS);

  logic             rxd_s1_q, rxd_s1_d;
  logic             rxd_s2_q, rxd_s2_d;
  logic             rxd_prev_q, rxd_prev_d;
  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hi_q, hi_d;
  logic             have_hi_q, have_hi_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [15:0]      rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_error_q, rx_error_d;

  logic tick;
  logic fall;

  assign tick = (div_cnt_q == DIV_LAST);
  assign fall = rxd_prev_q & ~rxd_s2_q;

  always_comb begin
    rxd_s1_d   = rxd;
    rxd_s2_d   = rxd_s1_q;
    rxd_prev_d = rxd_s2_q;
    state_d    = state_q;
    div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    hi_d       = hi_q;
    have_hi_d  = have_hi_q;
    to_cnt_d   = to_cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_error_d = rx_error_q;

    if (!enable) begin
      state_d    = S_IDLE;
      div_cnt_d  = '0;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      have_hi_d  = 1'b0;
      to_cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fall) begin
            state_d    = S_START;
            div_cnt_d  = '0;
            tick_cnt_d = '0;
          end else if (have_hi_q && tick) begin
            // a held high byte expires if no start edge arrives in time
            if (to_cnt_q <= TO_W'(1)) begin
              have_hi_d = 1'b0;
              to_cnt_d  = '0;
            end else begin
              to_cnt_d = to_cnt_q - 1'b1;
            end
          end
        end
        S_START: begin
          if (tick) begin
            if (tick_cnt_q == 4'd7) begin
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
              state_d    = rxd_s2_q ? S_IDLE : S_DATA;
            end else begin
              tick_cnt_d = tick_cnt_q + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (tick_cnt_q == 4'd15) begin
              tick_cnt_d = '0;
              shift_d    = {rxd_s2_q, shift_q[7:1]};
              bit_cnt_d  = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_d = S_STOP;
            end else begin
              tick_cnt_d = tick_cnt_q + 4'd1;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (tick_cnt_q == 4'd15) begin
              tick_cnt_d = '0;
              if (rxd_s2_q) begin
                state_d = S_IDLE;
                if (have_hi_q) begin
                  rx_data_d  = {hi_q, shift_q};
                  rx_valid_d = 1'b1;
                  have_hi_d  = 1'b0;
                  to_cnt_d   = '0;
                end else begin
                  hi_d      = shift_q;
                  have_hi_d = 1'b1;
                  to_cnt_d  = TO_LOAD;
                end
              end else begin
                state_d    = S_WAIT_HI;
                have_hi_d  = 1'b0;
                to_cnt_d   = '0;
                rx_error_d = 1'b1;
              end
            end else begin
              tick_cnt_d = tick_cnt_q + 4'd1;
            end
          end
        end
        S_WAIT_HI: begin
          if (rxd_s2_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      hi_q       <= '0;
      have_hi_q  <= 1'b0;
      to_cnt_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_error_q <= 1'b0;
    end else begin
      rxd_s1_q   <= rxd_s1_d;
      rxd_s2_q   <= rxd_s2_d;
      rxd_prev_q <= rxd_prev_d;
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      hi_q       <= hi_d;
      have_hi_q  <= have_hi_d;
      to_cnt_q   <= to_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_error_q <= rx_error_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_error = rx_error_q;

endmodule

// File: tb/tb_dart_rx_word.sv
// Directed bench for dart_rx_word: 160 clocks per bit, table of word pairs plus corner sequences.
module tb_dart_rx_word;

  localparam int BIT_CLKS = 160;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        rxd;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_error;

  int total_checks = 0;
  int passed_checks = 0;
  int pulse_cnt = 0;
  int wide_cnt = 0;
  logic last_v = 1'b0;

  dart_rx_word #(
    .CLK_FREQ(1600000),
    .BAUD_RATE(10000),
    .TIMEOUT_BITS(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .rxd(rxd),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_error(rx_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rx_valid === 1'b1) begin
      pulse_cnt++;
      if (last_v) wide_cnt++;
    end
    last_v = (rx_valid === 1'b1);
  end

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    int          gap_bits;
    logic [15:0] exp_data;
    int          exp_pulses;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic drive_bits(input logic b, input int n);
    #1 rxd = b;
    repeat (n * BIT_CLKS) @(posedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) drive_bits(b[i], 1);
    drive_bits(stop_bit, 1);
  endtask

  task automatic settle();
    repeat (20) @(posedge clock);
    @(negedge clock);
  endtask

  int p0;

  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    rxd    = 1'b1;

    vecs[0] = '{hi: 8'hA5, lo: 8'h3C, gap_bits: 0,  exp_data: 16'hA53C, exp_pulses: 1};
    vecs[1] = '{hi: 8'hFF, lo: 8'h00, gap_bits: 3,  exp_data: 16'hFF00, exp_pulses: 1};
    vecs[2] = '{hi: 8'h80, lo: 8'h01, gap_bits: 10, exp_data: 16'h8001, exp_pulses: 1};
    vecs[3] = '{hi: 8'h00, lo: 8'hFF, gap_bits: 28, exp_data: 16'h00FF, exp_pulses: 1};

    // reset state
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("reset_data", {16'h0, rx_data}, 32'h0000);
    check("reset_valid", {31'h0, rx_valid}, 32'h0);
    check("reset_error", {31'h0, rx_error}, 32'h0);
    drive_bits(1'b1, 2);

    // table of word pairs with varying inter-byte gaps
    for (int v = 0; v < 4; v++) begin
      p0 = pulse_cnt;
      send_byte(vecs[v].hi, 1'b1);
      if (vecs[v].gap_bits > 0) drive_bits(1'b1, vecs[v].gap_bits);
      send_byte(vecs[v].lo, 1'b1);
      settle();
      check($sformatf("vec%0d_pulses", v), pulse_cnt - p0, vecs[v].exp_pulses);
      check($sformatf("vec%0d_data", v), {16'h0, rx_data}, {16'h0, vecs[v].exp_data});
      check($sformatf("vec%0d_error", v), {31'h0, rx_error}, 32'h0);
      drive_bits(1'b1, 2);
    end

    // short low glitch must not start a byte
    p0 = pulse_cnt;
    #1 rxd = 1'b0;
    repeat (50) @(posedge clock);
    drive_bits(1'b1, 2);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    settle();
    check("glitch_pulses", pulse_cnt - p0, 1);
    check("glitch_data", {16'h0, rx_data}, 32'h0102);
    check("glitch_error", {31'h0, rx_error}, 32'h0);
    drive_bits(1'b1, 2);

    // lone byte times out; next pair forms the word
    p0 = pulse_cnt;
    send_byte(8'h55, 1'b1);
    drive_bits(1'b1, 40);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    settle();
    check("timeout_pulses", pulse_cnt - p0, 1);
    check("timeout_data", {16'h0, rx_data}, 32'h0102);
    drive_bits(1'b1, 2);

    // enable low drops the partial word and ignores the line
    p0 = pulse_cnt;
    send_byte(8'h11, 1'b1);
    #1 enable = 1'b0;
    send_byte(8'h44, 1'b1);
    settle();
    check("disabled_data_held", {16'h0, rx_data}, 32'h0102);
    check("disabled_pulses", pulse_cnt - p0, 0);
    #1 enable = 1'b1;
    drive_bits(1'b1, 1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    settle();
    check("enable_pulses", pulse_cnt - p0, 1);
    check("enable_data", {16'h0, rx_data}, 32'h2233);
    drive_bits(1'b1, 2);

    // framing error followed by a break, then a good word
    p0 = pulse_cnt;
    send_byte(8'h77, 1'b0);
    drive_bits(1'b0, 20);
    drive_bits(1'b1, 2);
    @(negedge clock);
    check("ferr_error", {31'h0, rx_error}, 32'h1);
    check("ferr_pulses", pulse_cnt - p0, 0);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    settle();
    check("ferr_next_pulses", pulse_cnt - p0, 1);
    check("ferr_next_data", {16'h0, rx_data}, 32'h1234);
    check("ferr_sticky", {31'h0, rx_error}, 32'h1);
    drive_bits(1'b1, 2);

    // reset during bit 4 of the second byte of 0xBEEF
    p0 = pulse_cnt;
    send_byte(8'hBE, 1'b1);
    drive_bits(1'b0, 1);
    for (int i = 0; i < 4; i++) drive_bits(1'(8'hEF >> i), 1);
    #1 rxd = 1'b0;
    repeat (80) @(posedge clock);
    #1 reset = 1'b0;
    rxd = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    drive_bits(1'b1, 12);
    @(negedge clock);
    check("abort_pulses", pulse_cnt - p0, 0);
    check("abort_data", {16'h0, rx_data}, 32'h0000);
    check("abort_error", {31'h0, rx_error}, 32'h0);
    send_byte(8'hCA, 1'b1);
    send_byte(8'hFE, 1'b1);
    settle();
    check("after_abort_pulses", pulse_cnt - p0, 1);
    check("after_abort_data", {16'h0, rx_data}, 32'hCAFE);

    check("valid_width", wide_cnt, 0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/dart_rx_word.md
DART_RX_WORD -- requirements
Module: dart_rx_word

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000: clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600: serial bit rate.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 32: idle bit times allowed between the two bytes of one word.
REQ-004 SHALL have port clock, input, 1: single clock for all logic.
REQ-005 SHALL have port reset, input, 1: reset is synchronous and active-low.
REQ-006 SHALL have port enable, input, 1: receiver runs only while high; tied to the clock-lock status.
REQ-007 SHALL have port rxd, input, 1: asynchronous RS-232 receive line, idle high.
REQ-008 SHALL have port rx_data, output, 16: last assembled word, feeding Control rx_word.
REQ-009 SHALL have port rx_valid, output, 1: one-cycle pulse, rx_data is new.
REQ-010 SHALL have port rx_error, output, 1: sticky framing-error flag.

Function
REQ-011 SHALL pass rxd through a two-flop synchronizer; both flops reset to 1; all decisions use the synchronized value.
REQ-012 SHALL generate a 16x oversample tick every DIV = CLK_FREQ/(BAUD_RATE*16) clocks, integer division truncating; the divider counter restarts at 0 on start-bit detection.
REQ-013 SHALL decode 8N1 frames, LSB first.
REQ-014 SHALL use FSM states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: falling edge (synchronized rxd 1->0) -> START; tick counter cleared.
REQ-016 START: sample rxd at tick 8; if 1, treat as glitch and return to IDLE with no flag; if 0 -> DATA.
REQ-017 DATA: sample every 16 ticks after the start mid-point; after 8 samples -> STOP.
REQ-018 STOP: sample at mid-bit; if 1, byte accepted -> IDLE; if 0, framing error -> WAIT_HIGH.
REQ-019 Framing error: byte and any partial word discarded; rx_error set to 1 and held until reset.
REQ-020 WAIT_HIGH: remain until synchronized rxd = 1, then IDLE; a line held low (break) SHALL NOT produce bytes.
REQ-021 The first accepted byte of a word SHALL go to bits [15:8]; the second SHALL go to bits [7:0].
REQ-022 On the second accepted byte, the block SHALL load rx_data and pulse rx_valid for exactly one clock, in the cycle after the stop-bit sample.
REQ-023 rx_data SHALL hold its value between pulses.
REQ-024 While holding a first byte, if no start bit is detected within TIMEOUT_BITS*16 ticks after its stop sample, the block SHALL discard it silently; the next byte becomes the high byte.
REQ-025 enable low SHALL force IDLE, clear the partial word and the timeout counter, and ignore rxd; rx_error and rx_data are unaffected.
REQ-026 Back-to-back frames SHALL be accepted: a start edge arriving immediately after the stop mid-sample is detected.

Reset
REQ-027 reset low at a clock edge SHALL force state IDLE, rx_data = 16'h0000, rx_valid = 0, rx_error = 0, partial word cleared, and all counters = 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame; no rx_valid SHALL follow from that frame.

Verification (bench: CLK_FREQ=1600000, BAUD_RATE=10000 -> DIV=10, 160 clocks/bit)
REQ-029 Reset held low for 3 cycles, rxd=1 -> rx_data=0x0000, rx_valid=0, rx_error=0.
REQ-030 Send 0xA5 then 0x3C back-to-back -> exactly one rx_valid pulse, rx_data=0xA53C, rx_error=0.
REQ-031 First byte with stop bit 0, line then held low 20 bit times, then high, then 0x12,0x34 -> rx_error=1 (stays), no pulse for the bad frame, then rx_data=0x1234 with one pulse.
REQ-032 Low glitch of 50 clocks on idle line, then 0x01,0x02 -> no spurious byte, rx_data=0x0102.
REQ-033 Send 0x55, idle 40 bit times, then 0x01,0x02 -> 0x55 dropped, one pulse, rx_data=0x0102.
REQ-034 Reset asserted during bit 4 of the second byte of 0xBEEF -> no pulse, rx_data=0x0000; next 0xCAFE -> rx_data=0xCAFE.
